// File: rtl/control_unit_cba_stream_if.sv
// rtl/control_unit_cba_stream_if.sv - gate stream, row handshake and datapath control bundle
interface control_unit_cba_stream_if #(
  parameter int NUM_QUBIT = 4
);
  logic                 valid_in;
  logic                 gate_valid;
  logic                 gate_ready;
  logic [2:0]           gate_type;
  logic [31:0]          qubit_pos;
  logic [31:0]          qubit_pos2;
  logic                 gate_last;
  logic [NUM_QUBIT-1:0] toggle_phase;
  logic                 ld_literal;
  logic                 shift_rotate_literal;
  logic                 rotate_update_literal;
  logic                 ld_c;
  logic                 ld_t;
  logic                 control_target;
  logic                 shift_toggle_phase;
  logic [NUM_QUBIT-1:0] ld_phase;
  logic [2:0]           cur_gate;
  logic                 valid_out;
  logic                 busy;
  logic                 gate_err;

  modport master (
    output valid_in, gate_valid, gate_type, qubit_pos, qubit_pos2, gate_last, toggle_phase,
    input  gate_ready, ld_literal, shift_rotate_literal, rotate_update_literal, ld_c, ld_t,
           control_target, shift_toggle_phase, ld_phase, cur_gate, valid_out, busy, gate_err
  );

  modport slave (
    input  valid_in, gate_valid, gate_type, qubit_pos, qubit_pos2, gate_last, toggle_phase,
    output gate_ready, ld_literal, shift_rotate_literal, rotate_update_literal, ld_c, ld_t,
           control_target, shift_toggle_phase, ld_phase, cur_gate, valid_out, busy, gate_err
  );
endinterface

// File: rtl/control_unit_cba_stream.sv
// rtl/control_unit_cba_stream.sv - streaming Clifford-gate sequencer over a rotating literal/phase tableau
module control_unit_cba_stream #(
  parameter int NUM_QUBIT  = 4,
  parameter int GATE_DEPTH = 8,
  parameter int CW         = $clog2(2*NUM_QUBIT)
) (
  input logic                      clk,
  input logic                      rst_n,
  control_unit_cba_stream_if.slave bus
);

  localparam int AW = $clog2(GATE_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(GATE_DEPTH);
  localparam logic [CW-1:0] NQ_CW   = CW'(NUM_QUBIT);
  localparam logic [CW-1:0] LAST1   = CW'(NUM_QUBIT - 1);
  localparam logic [CW-1:0] LAST2   = CW'(2*NUM_QUBIT - 1);
  localparam logic [31:0]   NQ32    = 32'(NUM_QUBIT);

  typedef enum logic [2:0] {LOAD, FETCH, ROT1, ROT2, UNLOAD} state_t;

  typedef struct packed {
    logic        last;
    logic [31:0] pos2;
    logic [31:0] pos;
    logic [2:0]  gtype;
  } gate_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    cur_type;
  logic [CW-1:0] cur_pos;
  logic [CW-1:0] cur_pos2;
  logic          cur_last;

  gate_t         mem [GATE_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  gate_t         head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          two_q;
  logic          illegal;
  logic [CW-1:0] pos_hi;
  logic [CW-1:0] pos2_hi;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign push  = bus.gate_valid && !full;
  assign pop   = (state == FETCH) && !empty;
  assign head  = mem[rd_ptr];

  // Positions are checked at full width so out-of-range values never alias after truncation.
  assign two_q   = (head.gtype == 3'd2) || (head.gtype == 3'd3) || (head.gtype == 3'd4);
  assign illegal = (head.gtype > 3'd4) || (head.pos >= NQ32) ||
                   (two_q && ((head.pos2 >= NQ32) || (head.pos2 == head.pos)));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{last: bus.gate_last, pos2: bus.qubit_pos2,
                       pos: bus.qubit_pos, gtype: bus.gate_type};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      cnt      <= '0;
      cur_type <= '0;
      cur_pos  <= '0;
      cur_pos2 <= '0;
      cur_last <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.valid_in) begin
            if (cnt == LAST1) begin
              cnt   <= '0;
              state <= FETCH;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FETCH: begin
          if (!empty) begin
            cur_type <= head.gtype;
            cur_pos  <= CW'(head.pos);
            cur_pos2 <= CW'(head.pos2);
            cur_last <= head.last;
            cnt      <= '0;
            if (illegal) begin
              state <= head.last ? UNLOAD : FETCH;
            end else begin
              state <= two_q ? ROT2 : ROT1;
            end
          end
        end
        ROT1: begin
          if (cnt == LAST1) begin
            cnt   <= '0;
            state <= cur_last ? UNLOAD : FETCH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ROT2: begin
          if (cnt == LAST2) begin
            cnt   <= '0;
            state <= cur_last ? UNLOAD : FETCH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        UNLOAD: begin
          if (cnt == LAST1) begin
            cnt   <= '0;
            state <= LOAD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= LOAD;
        end
      endcase
    end
  end

  // Second pass of ROT2 revisits each row one full rotation later to write back the update.
  assign pos_hi  = cur_pos + NQ_CW;
  assign pos2_hi = cur_pos2 + NQ_CW;

  always_comb begin
    bus.ld_literal            = 1'b0;
    bus.shift_rotate_literal  = 1'b0;
    bus.rotate_update_literal = 1'b0;
    bus.ld_c                  = 1'b0;
    bus.ld_t                  = 1'b0;
    bus.control_target        = 1'b0;
    bus.shift_toggle_phase    = 1'b0;
    bus.ld_phase              = '0;
    case (state)
      LOAD: begin
        bus.ld_literal = bus.valid_in;
        bus.ld_phase   = {NUM_QUBIT{bus.valid_in}};
      end
      ROT1: begin
        bus.ld_literal           = 1'b1;
        bus.shift_rotate_literal = 1'b1;
        if (cnt == cur_pos) begin
          bus.rotate_update_literal = 1'b1;
          bus.shift_toggle_phase    = 1'b1;
          bus.ld_phase              = bus.toggle_phase;
        end
      end
      ROT2: begin
        bus.ld_literal           = 1'b1;
        bus.shift_rotate_literal = 1'b1;
        if (cnt == cur_pos)  bus.ld_c = 1'b1;
        if (cnt == cur_pos2) bus.ld_t = 1'b1;
        if (cnt == pos_hi)   bus.rotate_update_literal = 1'b1;
        if (cnt == pos2_hi) begin
          bus.rotate_update_literal = 1'b1;
          bus.control_target        = 1'b1;
          bus.shift_toggle_phase    = 1'b1;
          bus.ld_phase              = bus.toggle_phase;
        end
      end
      UNLOAD: begin
        bus.ld_literal = 1'b1;
        bus.ld_phase   = '1;
      end
      default: ;
    endcase
  end

  assign bus.gate_ready = !full;
  assign bus.gate_err   = pop && illegal;
  assign bus.cur_gate   = cur_type;
  assign bus.valid_out  = (state == UNLOAD);
  assign bus.busy       = (state != LOAD);

endmodule
